// File: rtl/muldiv_pkg.sv
// Shared constants for the muldiv_engine: operation codes, FSM state encoding,
// default latencies and small helper functions.
package muldiv_pkg;

    localparam logic [3:0] MD_NOP   = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_counter.sv
// Loadable down-counter that times one muldiv operation; busy is registered and
// done flags the edge on which the count expires.
module muldiv_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         busy,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         busy_q, busy_d;

    // A load wins over expiry so a back-to-back operation keeps busy high.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (load) begin
            cnt_d  = value;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);

endmodule

// File: rtl/muldiv_engine.sv
// Fixed-latency multiply/divide engine committing into HI/LO.
// Optional MADD/MADDU accumulate is enabled by defining MULDIV_MADD_EN.
module muldiv_engine
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  ctrl,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    // Handshake: a request is taken on any edge where start=1 and busy=0, or on
    // the final busy edge (commit and launch coincide); while busy is high start is dropped.

    localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t   state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_ok_q, pend_ok_d;
    logic        accept;
    logic        cnt_load, cnt_done;
    logic [CNT_W-1:0] cnt_value;

    logic        mul_signed;
    logic [63:0] mul_a, mul_b, prod;
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, uquo, urem, quo, rem;

    assign mul_signed = (ctrl == MD_MULT)
`ifdef MULDIV_MADD_EN
                        || (ctrl == MD_MADD)
`endif
                        ;
    assign mul_a = {{32{mul_signed & A[31]}}, A};
    assign mul_b = {{32{mul_signed & B[31]}}, B};
    assign prod  = mul_a * mul_b;

    // Signed divide via magnitudes; a zero divisor is replaced so no X is produced.
    assign div_signed = (ctrl == MD_DIV);
    assign a_neg      = div_signed & A[31];
    assign b_neg      = div_signed & B[31];
    assign a_mag      = neg_if(a_neg, A);
    assign b_mag      = (B == 32'd0) ? 32'd1 : neg_if(b_neg, B);
    assign uquo       = a_mag / b_mag;
    assign urem       = a_mag % b_mag;
    assign quo        = neg_if(a_neg ^ b_neg, uquo);
    assign rem        = neg_if(a_neg, urem);

`ifdef MULDIV_MADD_EN
    logic [31:0] base_hi, base_lo;
    logic [63:0] acc;
    // A MADD launched on a commit edge accumulates onto the value being committed.
    assign base_hi = (state_q == ST_RUN && pend_ok_q) ? pend_hi_q : hi_q;
    assign base_lo = (state_q == ST_RUN && pend_ok_q) ? pend_lo_q : lo_q;
    assign acc     = {base_hi, base_lo} + prod;
`endif

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_ok_d = pend_ok_q;
        cnt_load  = 1'b0;
        cnt_value = '0;
        accept    = 1'b0;

        unique case (state_q)
            ST_IDLE: accept = start;
            ST_RUN: begin
                if (cnt_done) begin
                    state_d = ST_IDLE;
                    accept  = start;
                    if (pend_ok_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            case (ctrl)
                MD_MULT, MD_MULTU: begin
                    pend_hi_d = prod[63:32];
                    pend_lo_d = prod[31:0];
                    pend_ok_d = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_value = MULT_LOAD;
                    state_d   = ST_RUN;
                end
                MD_DIV, MD_DIVU: begin
                    pend_hi_d = rem;
                    pend_lo_d = quo;
                    pend_ok_d = (B != 32'd0);
                    cnt_load  = 1'b1;
                    cnt_value = DIV_LOAD;
                    state_d   = ST_RUN;
                end
                MD_MTHI: hi_d = A;
                MD_MTLO: lo_d = A;
`ifdef MULDIV_MADD_EN
                MD_MADD, MD_MADDU: begin
                    pend_hi_d = acc[63:32];
                    pend_lo_d = acc[31:0];
                    pend_ok_d = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_value = MULT_LOAD;
                    state_d   = ST_RUN;
                end
`else
                MD_NOP, MD_MADD, MD_MADDU: ;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_ok_q <= pend_ok_d;
        end
    end

    muldiv_counter #(
        .W(CNT_W)
    ) u_counter (
        .clk  (clk),
        .reset(reset),
        .load (cnt_load),
        .value(cnt_value),
        .busy (busy),
        .done (cnt_done)
    );

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: doc/muldiv_engine.md
# muldiv_engine

Iterative-latency multiply/divide execution engine for the MIPS pipeline's E stage. It sits directly downstream of the multiply unit's operand/control source registers and consumes their latched `A`, `B` and `real_ctrl`. It commits results into the architectural HI/LO registers after a fixed per-operation latency, and reports `busy` so hazard control can stall dependent instructions.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for multiply-class operations.
- `DIV_CYCLES`, default 10: busy cycles for divide-class operations.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: operation request; `A`, `B` and `ctrl` are valid in the same cycle.
- `A`  in  32: operand rs, from the source registers.
- `B`  in  32: operand rt, from the source registers.
- `ctrl`  in  4: operation code, from `real_ctrl`.
- `busy`  out  1: operation in flight.
- `HI`  out  32: architectural HI.
- `LO`  out  32: architectural LO.

## Operation
ctrl encoding:
- 0: NOP.
- 1: MULT, signed 32x32 to 64; HI = upper half, LO = lower half.
- 2: MULTU, unsigned 32x32 to 64.
- 3: DIV, signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- 4: DIVU, unsigned quotient and remainder.
- 5: MTHI, HI = A.
- 6: MTLO, LO = A.
- 7–15: reserved, treated as NOP. 7/8 are reserved unless the configuration macro is defined.

State machine has two states, IDLE and RUN.
- IDLE with `start=1` and a mult/div code: compute the result and store it in internal pending registers `pend_hi` and `pend_lo`. Load the counter with N-1, where N is the latency for that class. Go to RUN.
- IDLE with `start=1` and MTHI/MTLO: write HI or LO at that edge and stay in IDLE.
- IDLE with `start=1` and NOP/reserved: no state change.
- RUN: decrement the counter each edge. When it reaches 0, copy `pend_hi`/`pend_lo` into HI/LO at that same edge and go to IDLE.
- RUN with `start=1`: the request is ignored. Upstream must stall while `busy` is high.

Arithmetic rules:
- 64-bit product computed on the full width.
- DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (B=0, DIV or DIVU) keeps the full DIV_CYCLES latency but commits nothing; HI and LO keep their old values.
- HI and LO are never partially updated during RUN.

## Timing
- Reset asserted (`reset`=0), at any time including mid-RUN: state=IDLE, counter=0, `busy`=0, HI=0, LO=0, pending registers=0. The in-flight operation is discarded.
- `busy` is a registered output. If `start` is sampled at edge T with a mult/div code, `busy`=1 from after edge T until edge T+N, where it falls. `busy` is therefore high for exactly N cycles.
- HI/LO hold the new values from edge T+N. A new `start` is accepted at edge T+N: the commit and the new operation's launch happen at the same edge.
- MTHI/MTLO: result visible after edge T; `busy` never rises.
- Outputs change only on `clk` edges or on reset assertion.

## Configuration
- `MULDIV_MADD_EN` defined:
  - ctrl 7 = MADD: {HI,LO} += signed A*B, with 64-bit wrap.
  - ctrl 8 = MADDU: unsigned accumulate.
  - Both use MULT_CYCLES latency.
  - The accumulation base is HI/LO as sampled at the start edge.
- Not defined: codes 7 and 8 are NOPs and no accumulator adder is synthesized.

## Structure
- Shared package `muldiv_pkg`:
  - ctrl code constants (`MD_NOP` … `MD_MADDU`).
  - State encoding for IDLE and RUN.
  - Default latency constants.
- One sub-module, `muldiv_counter`:
  - Loadable down-counter.
  - Inputs: `load`, `value`.
  - Outputs: `busy`, and `done` pulsed when the count reaches 0.
- The top level holds the result datapath, the pending registers and the HI/LO registers.

## Test plan
- MULT A=0xFFFFFFFE (-2), B=3: `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2: `busy` high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 gives LO=3, HI=1.
- HI/LO preloaded via MTHI 0x11 and MTLO 0x22, then DIV by 0: `busy` high for 10 cycles, HI=0x11 and LO=0x22 unchanged. MTHI updates one edge after `start` with `busy` staying 0.
- MULT launched, then `start` with MTLO asserted in cycle 2: the MTLO is ignored. Back-to-back MULT issued at the commit edge: the second completes exactly 5 cycles later.
- `reset` pulled low in cycle 4 of a DIV: `busy`, HI and LO go to 0 immediately. After release, nothing commits.
- With `MULDIV_MADD_EN`, HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1: HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus leaves HI/LO unchanged and `busy` stays 0.
